// File: rtl/sram_mem_controller.sv
// MEM-stage bridge to a 16-bit external SRAM: each 32-bit load/store becomes two
// fixed-length halfword accesses, low half first, while ready stalls the pipeline.
module sram_mem_controller #(
    parameter int ADDR_BASE     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(ADDR_BASE);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [16:0] index_q, index_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] offset;
    logic        offset_unused;
    logic        request;
    logic        last_cycle;

    // Only bits [18:2] of the wrapped offset select the SRAM word.
    assign offset        = address - BASE;
    assign offset_unused = ^{offset[31:19], offset[1:0]};
    assign request       = rd_en | wr_en;
    assign last_cycle    = (cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    state_d    = LOW;
                    cnt_d      = 4'd0;
                    is_write_d = wr_en;
                    index_d    = offset[18:2];
                    wdata_d    = write_data;
                end
            end
            LOW: begin
                if (last_cycle) begin
                    state_d = HIGH;
                    cnt_d   = 4'd0;
                    if (!is_write_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (last_cycle) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!is_write_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_write_q  <= 1'b0;
            index_q     <= 17'd0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            index_q     <= index_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // SRAM pins decode straight from the state register so a reset drops strobes at once.
    always_comb begin
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            LOW: begin
                sram_addr = {index_q, 1'b0};
                if (is_write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
            end
            HIGH: begin
                sram_addr = {index_q, 1'b1};
                if (is_write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
            end
            default: begin
            end
        endcase
    end

    assign ready     = ((state_q == IDLE) && !request) || (state_q == DONE);
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller: a word-level reference memory predicts each
// access, a negedge monitor checks pin sequences, latency and read data as accesses finish.
module tb_sram_mem_controller;

    localparam int N    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        rd1;
    logic        wr1;
    logic [31:0] addr1, wdata1, read_data1;
    logic        ready1;
    logic [17:0] sram1_addr;
    logic [15:0] sram1_dq_out, sram1_dq_in;
    logic        sram1_dq_oe, sram1_we_n;

    always #5 clk = ~clk;

    sram_mem_controller #(.ADDR_BASE(BASE), .ACCESS_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_mem_controller #(.ADDR_BASE(BASE), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd1), .wr_en(wr1),
        .address(addr1), .write_data(wdata1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram1_addr), .sram_dq_out(sram1_dq_out),
        .sram_dq_in(sram1_dq_in), .sram_dq_oe(sram1_dq_oe), .sram_we_n(sram1_we_n)
    );

    // Behavioural halfword SRAM shared by both controllers (only dut writes it).
    logic [15:0] sram_mem [0:262143];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] = sram_dq_out;
    end
    assign sram_dq_in  = sram_mem[sram_addr];
    assign sram1_dq_in = sram_mem[sram1_addr];

    typedef struct {
        bit          wr;
        logic [16:0] idx;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_read = 32'd0;
    int          checks = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    int          busy = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: got no matching event, expected one", name);
    endtask

    task automatic preloadWord(input int idx, input logic [31:0] v);
        ref_mem[idx]         = v;
        sram_mem[2*idx]      = v[15:0];
        sram_mem[2*idx + 1]  = v[31:16];
    endtask

    // Issues one request at posedge+1 and holds it until ready is seen, then
    // returns just after the edge that closes DONE with the request still asserted.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] data);
        txn_t        t;
        logic [31:0] off;
        int          waited;
        off    = addr - 32'(BASE);
        t.idx  = off[18:2];
        t.wr   = wr;
        t.data = data;
        if (wr) ref_mem[int'(t.idx)] = data;
        else    last_read = ref_mem[int'(t.idx)];
        t.exp_rd = last_read;
        exp_q.push_back(t);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ready && waited < 40);
        if (!ready) begin
            reportFail("ready_timeout");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dropRequests(input int cycles);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Monitor: busy counts cycles since acceptance; DONE is ready high with a request held.
    always @(negedge clk) begin
        txn_t t;
        logic half;
        if (rst_n && mon_en) begin
            if (!ready) begin
                if (busy == 0) begin
                    checkOutput("accept_pins", {sram_addr, sram_we_n, sram_dq_oe, sram_dq_out},
                                {18'd0, 1'b1, 1'b0, 16'd0});
                end else if (busy <= 2*N) begin
                    if (exp_q.size() == 0) begin
                        reportFail("busy_without_txn");
                    end else begin
                        t    = exp_q[0];
                        half = (busy > N);
                        checkOutput($sformatf("pins_c%0d", busy),
                                    {sram_addr, sram_we_n, sram_dq_oe, sram_dq_out},
                                    {t.idx, half, !t.wr, t.wr,
                                     t.wr ? (half ? t.data[31:16] : t.data[15:0]) : 16'h0});
                    end
                end
                busy++;
            end else if (rd_en || wr_en) begin
                if (exp_q.size() == 0) begin
                    reportFail("done_without_txn");
                end else begin
                    t = exp_q.pop_front();
                    checkOutput("latency", 64'(busy), 64'(2*N + 1));
                    checkOutput("read_data", read_data, t.exp_rd);
                    checkOutput("done_pins", {sram_addr, sram_we_n, sram_dq_oe, sram_dq_out},
                                {18'd0, 1'b1, 1'b0, 16'd0});
                end
                busy = 0;
            end else begin
                busy = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [16:0] idx;
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] ea;
        int          k;
        int          gap;

        rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        for (int i = 0; i < 32; i++) preloadWord(i, $urandom);
        preloadWord(32'h1FFFF, $urandom);
        preloadWord(1, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_read_data", read_data, 32'd0);
        checkOutput("reset_pins", {sram_addr, sram_we_n, sram_dq_oe, sram_dq_out},
                    {18'd0, 1'b1, 1'b0, 16'd0});
        checkOutput("reset_ready_n1", ready1, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'd0);
        dropRequests(1);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 32'd1032, 32'd0);
        dropRequests(2);
        applyStimulus(1'b1, 1'b1, 32'd1024, 32'hA5A55A5A);
        dropRequests(1);
        applyStimulus(1'b0, 1'b1, 32'd1036, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd1040, 32'd0);
        dropRequests(1);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            k   = int'($urandom_range(0, 32));
            idx = (k == 32) ? 17'h1FFFF : 17'(k);
            a   = 32'(BASE) + 32'(idx) * 32'd4 + 32'($urandom_range(0, 3))
                  + (32'($urandom_range(0, 7)) << 19);
            if (k == 32 && $urandom_range(0, 1) == 1) a = 32'd1020;
            d = $urandom;
            k = int'($urandom_range(0, 9));
            if (k < 4)      applyStimulus(1'b0, 1'b1, a, d);
            else if (k < 8) applyStimulus(1'b1, 1'b0, a, d);
            else            applyStimulus(1'b1, 1'b1, a, d);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) dropRequests(gap);
        end
        dropRequests(2);

        $display("[TB] reset during a write");
        mon_en = 1'b0;
        d = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        wr_en = 1'b1; address = 32'd1056; write_data = d;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pins", {sram_addr, sram_we_n, sram_dq_oe, sram_dq_out},
                    {18'd0, 1'b1, 1'b0, 16'd0});
        checkOutput("abort_read_data", read_data, 32'd0);
        wr_en = 1'b0;
        #1;
        checkOutput("abort_ready", ready, 1'b1);
        ref_mem[8] = {ref_mem[8][31:16], d[15:0]};
        last_read = 32'd0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        busy = 0;
        mon_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'd1056, 32'd0);
        dropRequests(2);

        $display("[TB] single-cycle phases with wrapped address");
        rd1 = 1'b1; addr1 = 32'd1020;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            case (c)
                1:       ea = 18'h3FFFE;
                2:       ea = 18'h3FFFF;
                default: ea = 18'h0;
            endcase
            checkOutput($sformatf("n1_ready_c%0d", c), ready1, (c == 3));
            checkOutput($sformatf("n1_addr_c%0d", c), sram1_addr, ea);
            if (c == 3) checkOutput("n1_read_data", read_data1, ref_mem[32'h1FFFF]);
        end
        @(posedge clk);
        #1;
        rd1 = 1'b0;
        repeat (2) @(posedge clk);

        checkOutput("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage controller between the MEM stage and a 16-bit external SRAM. It turns one 32-bit load or store into two fixed-length halfword SRAM accesses and returns the loaded word on `read_data`, which feeds the MEM/WB register's data-memory input. While an access is in flight it holds `ready` low. The pipeline drives its stage-register `freeze` from `!ready`, so the whole pipeline stalls until the access completes.

## Interface
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2: clocks per halfword phase; legal range 1–15.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rd_en` in 1: load request from the MEM stage; held until `ready`.
- `wr_en` in 1: store request; held until `ready`.
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data.
- `read_data` out 32: last completed load word (registered).
- `ready` out 1: high when no access is pending; the pipeline freezes on `!ready`.
- `sram_addr` out 18: halfword address.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_dq_oe` out 1: drive enable for `sram_dq_out`.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- **States.** IDLE, LOW, HIGH, DONE.
- **Request precedence.** A request is `rd_en | wr_en`. If both are high, the write wins and the read is ignored for that request.
- **IDLE.** On a request, latch the following, then go to LOW with the phase counter at 0:
  - op (write/read);
  - word index = (`address` − `ADDR_BASE`)[18:2], using 32-bit subtraction that wraps modulo 2^32;
  - `write_data`.
- **Latched values.** Changes to `address`, `write_data`, `rd_en` or `wr_en` after acceptance are ignored until the next IDLE.
- **LOW.** `sram_addr` = {index, 1'b0}. Stay `ACCESS_CYCLES` clocks, then go to HIGH with the counter reset.
- **HIGH.** `sram_addr` = {index, 1'b1}. Stay `ACCESS_CYCLES` clocks, then go to DONE.
- **DONE.** Lasts exactly one clock, then returns to IDLE unconditionally. A request present in that next IDLE cycle is a new access.
- **Writes.** In LOW/HIGH, `sram_we_n`=0 and `sram_dq_oe`=1. `sram_dq_out` = latched data [15:0] in LOW and [31:16] in HIGH.
- **Reads.** `sram_we_n`=1 and `sram_dq_oe`=0. On the last clock of LOW, capture `sram_dq_in` into `read_data`[15:0]; on the last clock of HIGH, into `read_data`[31:16]. Writes never modify `read_data`.
- **Outputs in IDLE/DONE.** `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- **`ready`.** Combinational: (IDLE & !(`rd_en`|`wr_en`)) | DONE.
- **Reset values.** State IDLE, counter 0, `read_data`=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0, so `ready`=1 when no request is present.
- **Reset mid-access.** Abort immediately, with no further SRAM strobes. A write aborted in HIGH leaves the low half already written; this is accepted. A read aborted mid-access clears `read_data` to 0.

## Timing
- **Read/write latency.** Request first seen in IDLE at cycle 0, with `ready` low from cycle 0.
  - LOW occupies cycles 1..N and HIGH occupies N+1..2N, where N=`ACCESS_CYCLES`.
  - DONE is cycle 2N+1, with `ready`=1.
  - Default N=2: `ready` is high in cycle 5.
- **Read data valid.** `read_data` holds the new word from cycle 2N+1 (DONE) onward, stable until the next read's LOW capture.
- **Back-to-back accesses.** Each costs 2N+2 cycles. The IDLE accept cycle always has `ready`=0.
- **Frozen pipeline.** Requests stay asserted through DONE. The stage registers advance on the edge closing DONE, so no duplicate access occurs.
- **`ready` path.** Depends combinationally on `rd_en`/`wr_en` in IDLE only; no SRAM input reaches `ready`.

## Test plan
- **Read, N=2, `ADDR_BASE`=1024.** Preload SRAM halfwords 2=0xBEEF and 3=0xDEAD. Read at `address`=1028 → `sram_addr` 2 for cycles 1–2 and 3 for cycles 3–4; `ready`=0 in cycles 0–4; cycle 5 `ready`=1 and `read_data`=0xDEADBEEF.
- **Write then read.** Write 0x12345678 to 1032 → `sram_we_n`=0 in cycles 1–4, `sram_dq_out` 0x5678@addr4 then 0x1234@addr5, `read_data` unchanged. Then read 1032 → 0x12345678.
- **Both enables.** `rd_en`=`wr_en`=1 at 1024 with data 0xA5A5_5A5A → write performed, `read_data` unchanged, single 6-cycle access.
- **Back-to-back loads.** Requests held for two consecutive instructions → second access accepted in the IDLE after DONE; second `ready` pulse 6 cycles after the first; no access skipped or repeated.
- **Reset mid-write.** Assert `rst_n`=0 in cycle 3 of a write → same cycle `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `ready`=1 with no request; after release, a new read works normally.
- **Address wrap and N=1.** With `ACCESS_CYCLES`=1, read `address`=1020 → index 0x1FFFF, `sram_addr` 0x3FFFE then 0x3FFFF, `ready` high in cycle 3.
